// File: rtl/memory_access_arbiter_pkg.sv
// mem_arb_pkg: shared types and memory-bus encodings for memory_access_arbiter.
// Rev 1.0
`default_nettype none

package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_DATA  = 1'b1
   } owner_t;

   localparam logic [1:0] MEM_READ  = 2'b00;
   localparam logic [1:0] MEM_WRITE = 2'b01;
   localparam logic [1:0] MEM_HIZ   = 2'b10;

   // Under contention the requester not served last wins.
   function automatic owner_t pick_owner(input logic fetch_req, input logic data_req,
                                         input owner_t last_served);
      if (fetch_req && data_req)
         return (last_served == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
      else if (data_req)
         return OWN_DATA;
      else
         return OWN_FETCH;
   endfunction

endpackage

`default_nettype wire

// File: rtl/memory_access_arbiter_if.sv
// memory_access_arbiter_if: requester (fetch/data) and memory-port signals of the arbiter.
// Rev 1.0
`default_nettype none

interface memory_access_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();
   logic              Fetch_Req;
   logic [ADDR_W-1:0] Fetch_Address;
   logic              Fetch_Done;
   logic [DATA_W-1:0] Fetch_Data;
   logic              Data_Req;
   logic              Data_Write;
   logic [ADDR_W-1:0] Data_Address;
   logic [DATA_W-1:0] Data_Wdata;
   logic              Data_Done;
   logic [DATA_W-1:0] Data_Rdata;
   logic              Access_Error;
   logic              Busy;
   logic [ADDR_W-1:0] MEM_Address;
   logic [DATA_W-1:0] MEM_Data_In;
   logic [1:0]        MEM_r_w_z_z;
   logic [DATA_W-1:0] MEM_Data_Out;
   logic              MEM_MFC;
   logic              MEM_ERROR;

   modport slave (
      input  Fetch_Req, Fetch_Address, Data_Req, Data_Write, Data_Address, Data_Wdata,
             MEM_Data_Out, MEM_MFC, MEM_ERROR,
      output Fetch_Done, Fetch_Data, Data_Done, Data_Rdata, Access_Error, Busy,
             MEM_Address, MEM_Data_In, MEM_r_w_z_z
   );

   modport master (
      output Fetch_Req, Fetch_Address, Data_Req, Data_Write, Data_Address, Data_Wdata,
             MEM_Data_Out, MEM_MFC, MEM_ERROR,
      input  Fetch_Done, Fetch_Data, Data_Done, Data_Rdata, Access_Error, Busy,
             MEM_Address, MEM_Data_In, MEM_r_w_z_z
   );
endinterface

`default_nettype wire

// File: rtl/memory_access_arbiter_watchdog.sv
// mem_arb_watchdog: counts ACCESS cycles, flags expiry at TIMEOUT (built only with MEM_ARB_TIMEOUT_EN).
// Rev 1.0
`default_nettype none

`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_watchdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic count_en,
   output logic expired
);
   logic [7:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= 8'd0;
      else if (clear)
         count <= 8'd0;
      else if (count_en)
         count <= count + 8'd1;
   end

   // count holds the number of completed ACCESS cycles, so expiry is seen during the TIMEOUT-th one.
   assign expired = count_en && (count == 8'(TIMEOUT - 1));
endmodule
`endif

`default_nettype wire

// File: rtl/memory_access_arbiter.sv
// memory_access_arbiter: round-robin sharing of one MFC-handshake memory port between fetch and data access.
// Optional access watchdog enabled by defining MEM_ARB_TIMEOUT_EN.  Rev 1.0
`default_nettype none

module memory_access_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input logic                    Clock,
   input logic                    Reset_n,
   memory_access_arbiter_if.slave bus
);
   state_t            state,        state_next;
   owner_t            owner,        owner_next;
   owner_t            last_served,  last_served_next;
   owner_t            grant;
   logic              fetch_done,   fetch_done_next;
   logic              data_done,    data_done_next;
   logic              access_error, access_error_next;
   logic [DATA_W-1:0] fetch_data,   fetch_data_next;
   logic [DATA_W-1:0] data_rdata,   data_rdata_next;
   logic [ADDR_W-1:0] mem_address,  mem_address_next;
   logic [DATA_W-1:0] mem_data_in,  mem_data_in_next;
   logic [1:0]        mem_rwzz,     mem_rwzz_next;
   logic              timeout_hit;

   if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
      $error("memory_access_arbiter: TIMEOUT must be within 2..255");
   end

`ifdef MEM_ARB_TIMEOUT_EN
   mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk      (Clock),
      .rst_n    (Reset_n),
      .clear    (state != ACCESS),
      .count_en (state == ACCESS),
      .expired  (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state        <= IDLE;
         owner        <= OWN_FETCH;
         last_served  <= OWN_DATA;
         fetch_done   <= 1'b0;
         data_done    <= 1'b0;
         access_error <= 1'b0;
         fetch_data   <= '0;
         data_rdata   <= '0;
         mem_address  <= '0;
         mem_data_in  <= '0;
         mem_rwzz     <= MEM_HIZ;
      end else begin
         state        <= state_next;
         owner        <= owner_next;
         last_served  <= last_served_next;
         fetch_done   <= fetch_done_next;
         data_done    <= data_done_next;
         access_error <= access_error_next;
         fetch_data   <= fetch_data_next;
         data_rdata   <= data_rdata_next;
         mem_address  <= mem_address_next;
         mem_data_in  <= mem_data_in_next;
         mem_rwzz     <= mem_rwzz_next;
      end
   end

   always_comb begin
      state_next        = state;
      owner_next        = owner;
      last_served_next  = last_served;
      fetch_done_next   = 1'b0;
      data_done_next    = 1'b0;
      access_error_next = 1'b0;
      fetch_data_next   = fetch_data;
      data_rdata_next   = data_rdata;
      mem_address_next  = mem_address;
      mem_data_in_next  = mem_data_in;
      mem_rwzz_next     = mem_rwzz;
      grant             = pick_owner(bus.Fetch_Req, bus.Data_Req, last_served);

      case (state)
         IDLE: begin
            if (bus.Fetch_Req || bus.Data_Req) begin
               state_next       = ACCESS;
               owner_next       = grant;
               last_served_next = grant;
               if (grant == OWN_DATA) begin
                  mem_address_next = bus.Data_Address;
                  mem_data_in_next = bus.Data_Wdata;
                  mem_rwzz_next    = bus.Data_Write ? MEM_WRITE : MEM_READ;
               end else begin
                  mem_address_next = bus.Fetch_Address;
                  mem_data_in_next = '0;
                  mem_rwzz_next    = MEM_READ;
               end
            end
         end
         ACCESS: begin
            // An MFC landing on the watchdog expiry edge still counts as a normal completion.
            if (bus.MEM_ERROR || (timeout_hit && !bus.MEM_MFC)) begin
               state_next        = RESP;
               mem_rwzz_next     = MEM_HIZ;
               access_error_next = 1'b1;
               fetch_done_next   = (owner == OWN_FETCH);
               data_done_next    = (owner == OWN_DATA);
               if (mem_rwzz == MEM_READ) begin
                  if (owner == OWN_FETCH) fetch_data_next = '0;
                  else                    data_rdata_next = '0;
               end
            end else if (bus.MEM_MFC) begin
               state_next      = RESP;
               mem_rwzz_next   = MEM_HIZ;
               fetch_done_next = (owner == OWN_FETCH);
               data_done_next  = (owner == OWN_DATA);
               if (mem_rwzz == MEM_READ) begin
                  if (owner == OWN_FETCH) fetch_data_next = bus.MEM_Data_Out;
                  else                    data_rdata_next = bus.MEM_Data_Out;
               end
            end
         end
         RESP:    state_next = IDLE;
         default: begin
            state_next    = IDLE;
            mem_rwzz_next = MEM_HIZ;
         end
      endcase
   end

   assign bus.Fetch_Done   = fetch_done;
   assign bus.Fetch_Data   = fetch_data;
   assign bus.Data_Done    = data_done;
   assign bus.Data_Rdata   = data_rdata;
   assign bus.Access_Error = access_error;
   assign bus.Busy         = (state != IDLE);
   assign bus.MEM_Address  = mem_address;
   assign bus.MEM_Data_In  = mem_data_in;
   assign bus.MEM_r_w_z_z  = mem_rwzz;
endmodule

`default_nettype wire

// File: tb/tb_memory_access_arbiter.sv
// tb_memory_access_arbiter: vector table + scoreboard bench for memory_access_arbiter.
`default_nettype none

module tb_memory_access_arbiter;
   import mem_arb_pkg::*;

   localparam int TB_TIMEOUT = 4;

   typedef struct {
      bit          is_data;
      bit          write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          delay;
      bit          err;
      bit          drop;
   } vec_t;

   typedef struct {
      bit          is_data;
      logic [31:0] data;
      bit          err;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   memory_access_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   memory_access_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TB_TIMEOUT)) dut (
      .Clock   (clk),
      .Reset_n (rst_n),
      .bus     (bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_done   = 0;
   exp_t        sb[$];
   int          mem_delay  = 0;
   bit          mem_err    = 1'b0;
   bit          mem_silent = 1'b0;
   bit          chk_bus    = 1'b0;
   logic [31:0] mem_rdata  = 32'h0;
   logic [31:0] exp_addr   = 32'h0;
   logic [31:0] exp_wdata  = 32'h0;
   logic [1:0]  exp_rwzz   = MEM_READ;
   int          acc_cnt    = 0;
   logic [31:0] fetch_model = 32'h0;
   logic [31:0] rdata_model = 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Memory responder: sole driver of the MEM_* inputs.
   always @(negedge clk) begin
      bus.MEM_Data_Out = mem_rdata;
      if (bus.MEM_r_w_z_z == MEM_HIZ) begin
         acc_cnt       = 0;
         bus.MEM_MFC   = 1'b0;
         bus.MEM_ERROR = 1'b0;
      end else begin
         if (acc_cnt == 0 && chk_bus) begin
            check("bus_addr", bus.MEM_Address, exp_addr);
            check("bus_rwzz", {30'd0, bus.MEM_r_w_z_z}, {30'd0, exp_rwzz});
            if (exp_rwzz == MEM_WRITE) check("bus_wdata", bus.MEM_Data_In, exp_wdata);
         end
         if (!mem_silent && acc_cnt == mem_delay) begin
            bus.MEM_MFC   = !mem_err;
            bus.MEM_ERROR = mem_err;
         end
         acc_cnt++;
      end
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && (bus.Fetch_Done || bus.Data_Done)) begin
         n_done++;
         check("single_done", {31'd0, bus.Fetch_Done & bus.Data_Done}, 32'd0);
         check("resp_hiz", {30'd0, bus.MEM_r_w_z_z}, {30'd0, MEM_HIZ});
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got Fetch_Done=%0b Data_Done=%0b, required none",
                     bus.Fetch_Done, bus.Data_Done);
         end else begin
            e = sb.pop_front();
            check("done_owner", {31'd0, bus.Data_Done}, {31'd0, e.is_data});
            check("done_data", e.is_data ? bus.Data_Rdata : bus.Fetch_Data, e.data);
            check("access_error", {31'd0, bus.Access_Error}, {31'd0, e.err});
         end
      end
   end

   task automatic push_expect(input vec_t v, input bit silent);
      exp_t e;
      e.is_data = v.is_data;
      e.err     = v.err | silent;
      if (!v.is_data) begin
         fetch_model = e.err ? 32'h0 : v.rdata;
         e.data      = fetch_model;
      end else begin
         if (!v.write) rdata_model = e.err ? 32'h0 : v.rdata;
         e.data = rdata_model;
      end
      sb.push_back(e);
   endtask

   task automatic run_vec(input vec_t v, input bit silent);
      int lat;
      bit seen;
      int exp_lat;
      exp_lat    = silent ? TB_TIMEOUT + 1 : v.delay + 2;
      mem_delay  = v.delay;
      mem_err    = v.err;
      mem_silent = silent;
      mem_rdata  = v.rdata;
      exp_addr   = v.addr;
      exp_wdata  = v.wdata;
      exp_rwzz   = (v.is_data && v.write) ? MEM_WRITE : MEM_READ;
      chk_bus    = 1'b1;
      push_expect(v, silent);
      @(negedge clk);
      if (v.is_data) begin
         bus.Data_Req     = 1'b1;
         bus.Data_Write   = v.write;
         bus.Data_Address = v.addr;
         bus.Data_Wdata   = v.wdata;
      end else begin
         bus.Fetch_Req     = 1'b1;
         bus.Fetch_Address = v.addr;
      end
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 300) begin
         @(negedge clk);
         lat++;
         seen = bus.Fetch_Done | bus.Data_Done;
         if (lat == 1 && v.drop) begin
            bus.Fetch_Req     = 1'b0;
            bus.Data_Req      = 1'b0;
            bus.Fetch_Address = 32'hBAD0;
            bus.Data_Address  = 32'hBAD4;
            bus.Data_Write    = ~v.write;
         end
      end
      bus.Fetch_Req = 1'b0;
      bus.Data_Req  = 1'b0;
      check("latency", lat, exp_lat);
      @(negedge clk);
      check("done_width", {31'd0, bus.Fetch_Done | bus.Data_Done}, 32'd0);
      chk_bus    = 1'b0;
      mem_silent = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: run still active, required completion");
      $fatal(1);
   end

   initial begin
      vec_t vecs[9];
      vec_t t;
      int   cnt;
      int   guard;
      int   done_before;
      int   busy_cnt;

      vecs[0] = '{1'b0, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 2, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 32'h20,   32'h12345678, 32'h0,        0, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 32'h30,   32'h0,        32'hCAFEF00D, 1, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 32'hFFFF, 32'h0,        32'h77777777, 0, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 32'h44,   32'h0,        32'h0BADF00D, 0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 32'h50,   32'hA5A5A5A5, 32'h0,        1, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 1'b0, 32'h48,   32'h0,        32'h66666666, 0, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 32'h34,   32'h0,        32'h87654321, 3, 1'b0, 1'b1};
      vecs[8] = '{1'b0, 1'b0, 32'h4C,   32'h0,        32'h13579BDF, 2, 1'b0, 1'b1};

      bus.Fetch_Req     = 1'b0;
      bus.Fetch_Address = 32'h0;
      bus.Data_Req      = 1'b0;
      bus.Data_Write    = 1'b0;
      bus.Data_Address  = 32'h0;
      bus.Data_Wdata    = 32'h0;

      #22;
      check("rst_busy",       {31'd0, bus.Busy},         32'd0);
      check("rst_rwzz",       {30'd0, bus.MEM_r_w_z_z},  {30'd0, MEM_HIZ});
      check("rst_fetch_done", {31'd0, bus.Fetch_Done},   32'd0);
      check("rst_data_done",  {31'd0, bus.Data_Done},    32'd0);
      check("rst_error",      {31'd0, bus.Access_Error}, 32'd0);
      check("rst_fetch_data", bus.Fetch_Data,            32'h0);
      check("rst_data_rdata", bus.Data_Rdata,            32'h0);
      check("rst_mem_addr",   bus.MEM_Address,           32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) run_vec(vecs[i], 1'b0);

      // Contention from reset: both requests held, expect FETCH, DATA, FETCH, DATA.
      @(negedge clk);
      rst_n       = 1'b0;
      fetch_model = 32'h0;
      rdata_model = 32'h0;
      mem_delay   = 0;
      mem_err     = 1'b0;
      mem_rdata   = 32'h55AA55AA;
      bus.Fetch_Req     = 1'b1;
      bus.Fetch_Address = 32'h100;
      bus.Data_Req      = 1'b1;
      bus.Data_Write    = 1'b0;
      bus.Data_Address  = 32'h200;
      for (int i = 0; i < 4; i++) begin
         t = '{i[0], 1'b0, 32'h0, 32'h0, 32'h55AA55AA, 0, 1'b0, 1'b0};
         push_expect(t, 1'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      cnt   = 0;
      guard = 0;
      while (cnt < 4 && guard < 100) begin
         @(negedge clk);
         guard++;
         if (bus.Fetch_Done || bus.Data_Done) cnt++;
      end
      bus.Fetch_Req = 1'b0;
      bus.Data_Req  = 1'b0;
      check("contention_count", cnt, 32'd4);
      repeat (4) @(negedge clk);
      check("contention_idle", {31'd0, bus.Busy}, 32'd0);

      // Reset asserted in the middle of an access.
      mem_silent = 1'b1;
      @(negedge clk);
      bus.Fetch_Req     = 1'b1;
      bus.Fetch_Address = 32'h80;
      repeat (2) @(negedge clk);
      check("pre_reset_busy", {31'd0, bus.Busy}, 32'd1);
      #2;
      rst_n         = 1'b0;
      bus.Fetch_Req = 1'b0;
      #1;
      check("async_rst_rwzz", {30'd0, bus.MEM_r_w_z_z}, {30'd0, MEM_HIZ});
      check("async_rst_busy", {31'd0, bus.Busy}, 32'd0);
      fetch_model = 32'h0;
      rdata_model = 32'h0;
      done_before = n_done;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      check("no_done_after_reset", n_done, done_before);
      mem_silent = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
      t = '{1'b0, 1'b0, 32'h60, 32'h0, 32'h11111111, 0, 1'b0, 1'b0};
      run_vec(t, 1'b1);
      t = '{1'b0, 1'b0, 32'h64, 32'h0, 32'h22222222, TB_TIMEOUT - 1, 1'b0, 1'b0};
      run_vec(t, 1'b0);
`else
      mem_silent = 1'b1;
      @(negedge clk);
      bus.Fetch_Req     = 1'b1;
      bus.Fetch_Address = 32'h60;
      busy_cnt = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus.Busy) busy_cnt++;
      end
      check("no_timeout_busy", busy_cnt, 32'd100);
      rst_n         = 1'b0;
      bus.Fetch_Req = 1'b0;
      fetch_model   = 32'h0;
      rdata_model   = 32'h0;
      @(negedge clk);
      rst_n      = 1'b1;
      mem_silent = 1'b0;
      repeat (2) @(negedge clk);
`endif

      check("scoreboard_empty", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
